cordic_share_arbiter: RTL and testbench

Shares one CORDIC pipeline between two AXI-Stream IQ requesters, e.g. two FM demodulation channels. It sits upstream of `cordic` and downstream of the two channel front-ends. Packet-aware round-robin arbitration selects which requester's samples enter the pipeline. A 1-bit tag FIFO records the source of every sample issued, and CORDIC results are routed back to the requester that owns them, in order.

---
 rtl/radio_pkg.sv | 17 +
 rtl/tag_fifo.sv | 63 ++++++
 rtl/cordic_share_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_cordic_share_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/radio_pkg.sv
// Shared types and defaults for the CORDIC sharing arbiter.
//   arb_state_t       : arbiter FSM state encoding
//   src_id_t          : requester identifier stored in the tag FIFO
//   TAG_DEPTH_DEFAULT : default number of samples in flight in the CORDIC
package radio_pkg;

    localparam int TAG_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    typedef logic src_id_t;

endpackage

// File: rtl/tag_fifo.sv
// 1-bit synchronous FIFO recording the owner of each sample inside the CORDIC.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, push_id   : enqueue one source id
//   pop             : dequeue the head entry
//   head            : source id at the head (valid when !empty)
//   full, empty     : occupancy flags
//   count           : number of stored entries, 0..DEPTH
module tag_fifo
    import radio_pkg::*;
#(
    parameter int DEPTH = TAG_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  src_id_t                  push_id,
    input  logic                     pop,
    output src_id_t                  head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // NOTE: storage is not reset; count/pointers define which entries are live,
    // so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            // Simultaneous push and pop leaves the fill level unchanged.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/cordic_share_arbiter.sv
// Shares one CORDIC pipeline between two AXI-Stream IQ requesters.
// Packet-aware round-robin arbitration feeds a single-stage issue register;
// a tag FIFO remembers each sample's owner so results are routed back in order.
// Ports:
//   s00_axis_aclk / s00_axis_aresetn : clock, asynchronous active-low reset
//   s00_axis_* / s01_axis_*          : requester 0 / 1 samples in
//   m00_axis_*                       : issue port to the CORDIC
//   s02_axis_*                       : results from the CORDIC
//   m01_axis_* / m02_axis_*          : results for requester 0 / 1
//   err_orphan                       : sticky, result seen with no sample in flight
module cordic_share_arbiter
    import radio_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_DEPTH  = TAG_DEPTH_DEFAULT,
    parameter int BURST_MAX  = 64
) (
    input  logic                      s00_axis_aclk,
    input  logic                      s00_axis_aresetn,
    input  logic                      s00_axis_tvalid,
    input  logic                      s00_axis_tlast,
    input  logic [DATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s00_axis_tstrb,
    output logic                      s00_axis_tready,
    input  logic                      s01_axis_tvalid,
    input  logic                      s01_axis_tlast,
    input  logic [DATA_WIDTH-1:0]     s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s01_axis_tstrb,
    output logic                      s01_axis_tready,
    output logic                      m00_axis_tvalid,
    output logic                      m00_axis_tlast,
    output logic [DATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m00_axis_tstrb,
    input  logic                      m00_axis_tready,
    input  logic                      s02_axis_tvalid,
    input  logic                      s02_axis_tlast,
    input  logic [DATA_WIDTH-1:0]     s02_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s02_axis_tstrb,
    output logic                      s02_axis_tready,
    output logic                      m01_axis_tvalid,
    output logic                      m01_axis_tlast,
    output logic [DATA_WIDTH-1:0]     m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m01_axis_tstrb,
    input  logic                      m01_axis_tready,
    output logic                      m02_axis_tvalid,
    output logic                      m02_axis_tlast,
    output logic [DATA_WIDTH-1:0]     m02_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m02_axis_tstrb,
    input  logic                      m02_axis_tready,
    output logic                      err_orphan
);

    localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
    localparam int CW = $clog2(TAG_DEPTH) + 1;
    localparam logic [CW-1:0] TAG_DEPTH_CNT = CW'(TAG_DEPTH);

    arb_state_t state;
    arb_state_t state_next;
    src_id_t    last_grant;
    logic [BW-1:0] beat_cnt;

    logic                    load;
    logic                    accept;
    logic                    end_burst;
    src_id_t                 src;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    in_last;
    logic [DATA_WIDTH/8-1:0] in_strb;

    src_id_t        tag_head;
    logic           tag_full;
    logic           tag_empty;
    logic [CW-1:0]  tag_count;
    logic           tag_pop;

    // Issue register may take a beat when it is empty or draining this cycle,
    // and only while the CORDIC has room for another tagged sample.
    assign load = (!m00_axis_tvalid || m00_axis_tready) && (tag_count < TAG_DEPTH_CNT);

    // NOTE: every always_comb output gets a default before the case so that no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_next      = state;
        s00_axis_tready = 1'b0;
        s01_axis_tready = 1'b0;
        accept          = 1'b0;
        src             = 1'b0;
        in_data         = s00_axis_tdata;
        in_last         = s00_axis_tlast;
        in_strb         = s00_axis_tstrb;

        case (state)
            IDLE: begin
                // Round-robin tie break: the requester not served last wins.
                if (s00_axis_tvalid && (!s01_axis_tvalid || last_grant == 1'b1)) begin
                    state_next = GNT0;
                end else if (s01_axis_tvalid) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                s00_axis_tready = load;
                accept          = s00_axis_tvalid && load;
            end
            GNT1: begin
                s01_axis_tready = load;
                accept          = s01_axis_tvalid && load;
                src             = 1'b1;
                in_data         = s01_axis_tdata;
                in_last         = s01_axis_tlast;
                in_strb         = s01_axis_tstrb;
            end
            default: state_next = IDLE;
        endcase

        end_burst = accept && (in_last || beat_cnt == BURST_LAST);
        if (end_burst) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            state <= state_next;
            if (end_burst) begin
                last_grant <= src;
                beat_cnt   <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tstrb  <= '0;
        end else if (accept) begin
            m00_axis_tvalid <= 1'b1;
            m00_axis_tlast  <= in_last;
            m00_axis_tdata  <= in_data;
            m00_axis_tstrb  <= in_strb;
        end else if (m00_axis_tready) begin
            m00_axis_tvalid <= 1'b0;
        end
    end

    tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (s00_axis_aclk),
        .rst_n   (s00_axis_aresetn),
        .push    (accept),
        .push_id (src),
        .pop     (tag_pop),
        .head    (tag_head),
        .full    (tag_full),
        .empty   (tag_empty),
        .count   (tag_count)
    );

    // Return path: purely combinational demux steered by the head tag.
    assign m01_axis_tvalid = s02_axis_tvalid && !tag_empty && (tag_head == 1'b0);
    assign m02_axis_tvalid = s02_axis_tvalid && !tag_empty && (tag_head == 1'b1);
    assign s02_axis_tready = !tag_empty && (tag_head ? m02_axis_tready : m01_axis_tready);
    assign tag_pop         = s02_axis_tvalid && s02_axis_tready;

    assign m01_axis_tdata = s02_axis_tdata;
    assign m01_axis_tlast = s02_axis_tlast;
    assign m01_axis_tstrb = s02_axis_tstrb;
    assign m02_axis_tdata = s02_axis_tdata;
    assign m02_axis_tlast = s02_axis_tlast;
    assign m02_axis_tstrb = s02_axis_tstrb;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            err_orphan <= 1'b0;
        end else if (s02_axis_tvalid && tag_empty) begin
            err_orphan <= 1'b1;
        end
    end

    // Load is gated by the fill level, so the FIFO can never see a push while full.
    a_no_push_full: assert property (@(posedge s00_axis_aclk) disable iff (!s00_axis_aresetn)
                                     !(accept && tag_full));

endmodule

// File: tb/tb_cordic_share_arbiter.sv
// Self-checking bench for cordic_share_arbiter with a latency-8 CORDIC stand-in.
module tb_cordic_share_arbiter;

    localparam int DW        = 32;
    localparam int SW        = DW / 8;
    localparam int TAG_DEPTH = 16;
    localparam int BURST_MAX = 4;
    localparam int LAT       = 8;
    localparam int MAXB      = 256;

    logic          clk = 1'b0;
    logic          s00_axis_aresetn = 1'b1;
    logic          s00_axis_tvalid, s00_axis_tlast, s00_axis_tready;
    logic [DW-1:0] s00_axis_tdata;
    logic [SW-1:0] s00_axis_tstrb;
    logic          s01_axis_tvalid, s01_axis_tlast, s01_axis_tready;
    logic [DW-1:0] s01_axis_tdata;
    logic [SW-1:0] s01_axis_tstrb;
    logic          m00_axis_tvalid, m00_axis_tlast, m00_axis_tready;
    logic [DW-1:0] m00_axis_tdata;
    logic [SW-1:0] m00_axis_tstrb;
    logic          s02_axis_tvalid, s02_axis_tlast, s02_axis_tready;
    logic [DW-1:0] s02_axis_tdata;
    logic [SW-1:0] s02_axis_tstrb;
    logic          m01_axis_tvalid, m01_axis_tlast, m01_axis_tready;
    logic [DW-1:0] m01_axis_tdata;
    logic [SW-1:0] m01_axis_tstrb;
    logic          m02_axis_tvalid, m02_axis_tlast, m02_axis_tready;
    logic [DW-1:0] m02_axis_tdata;
    logic [SW-1:0] m02_axis_tstrb;
    logic          err_orphan;

    always #5 clk = ~clk;

    cordic_share_arbiter #(
        .DATA_WIDTH (DW),
        .TAG_DEPTH  (TAG_DEPTH),
        .BURST_MAX  (BURST_MAX)
    ) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (s00_axis_aresetn),
        .s00_axis_tvalid  (s00_axis_tvalid),
        .s00_axis_tlast   (s00_axis_tlast),
        .s00_axis_tdata   (s00_axis_tdata),
        .s00_axis_tstrb   (s00_axis_tstrb),
        .s00_axis_tready  (s00_axis_tready),
        .s01_axis_tvalid  (s01_axis_tvalid),
        .s01_axis_tlast   (s01_axis_tlast),
        .s01_axis_tdata   (s01_axis_tdata),
        .s01_axis_tstrb   (s01_axis_tstrb),
        .s01_axis_tready  (s01_axis_tready),
        .m00_axis_tvalid  (m00_axis_tvalid),
        .m00_axis_tlast   (m00_axis_tlast),
        .m00_axis_tdata   (m00_axis_tdata),
        .m00_axis_tstrb   (m00_axis_tstrb),
        .m00_axis_tready  (m00_axis_tready),
        .s02_axis_tvalid  (s02_axis_tvalid),
        .s02_axis_tlast   (s02_axis_tlast),
        .s02_axis_tdata   (s02_axis_tdata),
        .s02_axis_tstrb   (s02_axis_tstrb),
        .s02_axis_tready  (s02_axis_tready),
        .m01_axis_tvalid  (m01_axis_tvalid),
        .m01_axis_tlast   (m01_axis_tlast),
        .m01_axis_tdata   (m01_axis_tdata),
        .m01_axis_tstrb   (m01_axis_tstrb),
        .m01_axis_tready  (m01_axis_tready),
        .m02_axis_tvalid  (m02_axis_tvalid),
        .m02_axis_tlast   (m02_axis_tlast),
        .m02_axis_tdata   (m02_axis_tdata),
        .m02_axis_tstrb   (m02_axis_tstrb),
        .m02_axis_tready  (m02_axis_tready),
        .err_orphan       (err_orphan)
    );

    typedef struct packed {
        logic          first;   // first beat of a burst chunk (index % BURST_MAX == 0)
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct packed {
        logic [SW-1:0] strb;
        logic          last;
        logic [DW-1:0] data;
        int            due;
    } cq_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    beat_t beats [2][MAXB];
    int    nb [2];
    int    ptr [2];
    int    res_ptr [2];
    bit    held [2];
    beat_t exp_issue [$];
    cq_t   cq [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] xform(input logic [DW-1:0] d);
        return {d[15:0], d[31:16]} ^ 32'h5A5A_5A5A;
    endfunction

    task automatic zero_inputs();
        s00_axis_tvalid = 0; s00_axis_tlast = 0; s00_axis_tdata = '0; s00_axis_tstrb = '0;
        s01_axis_tvalid = 0; s01_axis_tlast = 0; s01_axis_tdata = '0; s01_axis_tstrb = '0;
        s02_axis_tvalid = 0; s02_axis_tlast = 0; s02_axis_tdata = '0; s02_axis_tstrb = '0;
        m00_axis_tready = 0; m01_axis_tready = 0; m02_axis_tready = 0;
    endtask

    task automatic clear_model();
        cq.delete();
        exp_issue.delete();
        for (int r = 0; r < 2; r++) begin
            nb[r] = 0; ptr[r] = 0; res_ptr[r] = 0; held[r] = 0;
        end
    endtask

    // Reset with every input asserted; all outputs must still read 0.
    task automatic apply_reset();
        @(negedge clk);
        s00_axis_aresetn = 0;
        s00_axis_tvalid = 1; s01_axis_tvalid = 1; s02_axis_tvalid = 1;
        m00_axis_tready = 1; m01_axis_tready = 1; m02_axis_tready = 1;
        #1;
        check("rst_m00_tvalid", m00_axis_tvalid, 0);
        check("rst_m01_tvalid", m01_axis_tvalid, 0);
        check("rst_m02_tvalid", m02_axis_tvalid, 0);
        check("rst_treadys", {s00_axis_tready, s01_axis_tready, s02_axis_tready}, 0);
        check("rst_err_orphan", err_orphan, 0);
        repeat (2) @(negedge clk);
        zero_inputs();
        s00_axis_aresetn = 1;
        clear_model();
    endtask

    // Expected issue order from the arbitration rules: chunks of up to
    // BURST_MAX beats ending at tlast, alternating while both have work.
    task automatic build_expected();
        int p [2];
        int g, cnt;
        bit lg, done;
        p[0] = 0; p[1] = 0; lg = 1'b1;
        exp_issue.delete();
        while (p[0] < nb[0] || p[1] < nb[1]) begin
            if (p[0] < nb[0] && p[1] < nb[1]) g = lg ? 0 : 1;
            else                              g = (p[0] < nb[0]) ? 0 : 1;
            cnt = 0;
            do begin
                exp_issue.push_back(beats[g][p[g]]);
                cnt++;
                done = beats[g][p[g]].last || (cnt == BURST_MAX);
                p[g]++;
            end while (!done);
            lg = g[0];
        end
    endtask

    task automatic add_packet(input int r, input int len);
        for (int i = 0; i < len; i++) begin
            beats[r][nb[r]].first = ((i % BURST_MAX) == 0);
            beats[r][nb[r]].last  = (i == len - 1);
            beats[r][nb[r]].data  = {r[0], 31'($urandom)};
            nb[r]++;
        end
    endtask

    // One clock of randomized traffic plus scoreboard updates.
    task automatic run_cycle(input bit hold_m02, input int m00_rate);
        beat_t cur [2];
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            if (ptr[r] < nb[r]) begin
                // Gaps only inside a chunk, so IDLE decisions stay predictable.
                if (!held[r]) held[r] = beats[r][ptr[r]].first || ($urandom_range(0, 3) != 0);
                cur[r] = beats[r][ptr[r]];
            end else begin
                held[r] = 0;
                cur[r]  = '0;
            end
        end
        s00_axis_tvalid = held[0]; s00_axis_tlast = cur[0].last;
        s00_axis_tdata  = cur[0].data; s00_axis_tstrb = cur[0].data[3:0];
        s01_axis_tvalid = held[1]; s01_axis_tlast = cur[1].last;
        s01_axis_tdata  = cur[1].data; s01_axis_tstrb = cur[1].data[3:0];
        m00_axis_tready = ($urandom_range(0, 99) < m00_rate);
        if (cq.size() > 0 && cq[0].due <= cyc) begin
            s02_axis_tvalid = 1;
            s02_axis_tdata  = xform(cq[0].data);
            s02_axis_tlast  = cq[0].last;
            s02_axis_tstrb  = cq[0].strb;
        end else begin
            s02_axis_tvalid = 0; s02_axis_tdata = '0; s02_axis_tlast = 0; s02_axis_tstrb = '0;
        end
        m01_axis_tready = ($urandom_range(0, 2) != 0);
        m02_axis_tready = hold_m02 ? 1'b0 : ($urandom_range(0, 2) != 0);
        #1;
        if (s00_axis_tvalid && s00_axis_tready) begin ptr[0]++; held[0] = 0; end
        if (s01_axis_tvalid && s01_axis_tready) begin ptr[1]++; held[1] = 0; end
        if (m00_axis_tvalid && m00_axis_tready) begin
            check("issue_expected", exp_issue.size() > 0, 1);
            if (exp_issue.size() > 0) begin
                beat_t e;
                e = exp_issue.pop_front();
                check("issue_beat", {m00_axis_tstrb, m00_axis_tlast, m00_axis_tdata},
                      {e.data[3:0], e.last, e.data});
            end
            cq.push_back('{strb: m00_axis_tstrb, last: m00_axis_tlast,
                           data: m00_axis_tdata, due: cyc + LAT});
        end
        if (s02_axis_tvalid && s02_axis_tready) void'(cq.pop_front());
        if (m01_axis_tvalid && m01_axis_tready) begin
            check("res0_expected", res_ptr[0] < nb[0], 1);
            if (res_ptr[0] < nb[0]) begin
                check("res0_beat", {m01_axis_tstrb, m01_axis_tlast, m01_axis_tdata},
                      {beats[0][res_ptr[0]].data[3:0], beats[0][res_ptr[0]].last,
                       xform(beats[0][res_ptr[0]].data)});
                res_ptr[0]++;
            end
        end
        if (m02_axis_tvalid && m02_axis_tready) begin
            check("res1_expected", res_ptr[1] < nb[1], 1);
            if (res_ptr[1] < nb[1]) begin
                check("res1_beat", {m02_axis_tstrb, m02_axis_tlast, m02_axis_tdata},
                      {beats[1][res_ptr[1]].data[3:0], beats[1][res_ptr[1]].last,
                       xform(beats[1][res_ptr[1]].data)});
                res_ptr[1]++;
            end
        end
        cyc++;
    endtask

    function automatic bit all_done();
        return ptr[0] == nb[0] && ptr[1] == nb[1] && res_ptr[0] == nb[0] && res_ptr[1] == nb[1];
    endfunction

    task automatic run_until_done(input int budget, input int m00_rate);
        int n = 0;
        while (!all_done() && n < budget) begin
            run_cycle(1'b0, m00_rate);
            n++;
        end
        check("drain_in_budget", n < budget, 1);
        check("res0_count", res_ptr[0], nb[0]);
        check("res1_count", res_ptr[1], nb[1]);
        check("no_orphan", err_orphan, 0);
    endtask

    // Directed s00 sender: beat k carries IQ 0x000k_0000 (k from 1).
    task automatic drive_s00(input int len, input int stop_at);
        int k = 0;
        int guard = 0;
        m00_axis_tready = 1;
        while (k < stop_at && guard < 100) begin
            @(negedge clk);
            s00_axis_tvalid = 1;
            s00_axis_tdata  = DW'(k + 1) << 16;
            s00_axis_tlast  = (k == len - 1);
            s00_axis_tstrb  = '1;
            #1;
            if (s00_axis_tready) k++;
            guard++;
        end
        check("s00_progress", k, stop_at);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        zero_inputs();
        clear_model();
        apply_reset();

        // Orphan result: tready stays low, flag sets next cycle and sticks.
        @(negedge clk);
        s02_axis_tvalid = 1; s02_axis_tdata = 32'h1234_5678;
        m01_axis_tready = 1; m02_axis_tready = 1;
        #1;
        check("orphan_tready", s02_axis_tready, 0);
        check("orphan_not_yet", err_orphan, 0);
        check("orphan_no_route", {m01_axis_tvalid, m02_axis_tvalid}, 0);
        @(negedge clk);
        #1;
        check("orphan_set", err_orphan, 1);
        @(negedge clk);
        s02_axis_tvalid = 0;
        repeat (3) @(negedge clk);
        #1;
        check("orphan_sticky", err_orphan, 1);
        apply_reset();

        // Finish one s00 packet so the round-robin pointer favours s01,
        // then reset in the middle of a 5-beat packet.
        drive_s00(1, 1);
        @(negedge clk);
        s00_axis_tvalid = 0;
        repeat (2) @(negedge clk);
        drive_s00(5, 2);
        @(negedge clk);
        s00_axis_tvalid = 1; s00_axis_tdata = 32'h0003_0000; s00_axis_tlast = 0;
        #2;
        s00_axis_aresetn = 0;
        #1;
        check("midrst_m00_tvalid", m00_axis_tvalid, 0);
        check("midrst_out_valids", {m01_axis_tvalid, m02_axis_tvalid}, 0);
        check("midrst_err", err_orphan, 0);
        check("midrst_s00_tready", s00_axis_tready, 0);
        @(negedge clk);
        zero_inputs();
        s00_axis_aresetn = 1;
        clear_model();

        // Tie after reset goes to s00; IDLE cycle accepts nothing;
        // 1-cycle issue latency; 1 bubble before s01 is served.
        @(negedge clk);
        m00_axis_tready = 1;
        s00_axis_tvalid = 1; s00_axis_tdata = 32'hAAAA_0001; s00_axis_tlast = 1; s00_axis_tstrb = '1;
        s01_axis_tvalid = 1; s01_axis_tdata = 32'hBBBB_0002; s01_axis_tlast = 1; s01_axis_tstrb = '1;
        #1;
        check("idle_no_accept", {s00_axis_tready, s01_axis_tready}, 0);
        @(negedge clk);
        #1;
        check("tie_grant_s00", {s00_axis_tready, s01_axis_tready}, 2'b10);
        @(negedge clk);
        s00_axis_tvalid = 0;
        #1;
        check("issue_latency_valid", m00_axis_tvalid, 1);
        check("issue_latency_data", m00_axis_tdata, 32'hAAAA_0001);
        check("bubble_no_grant", s01_axis_tready, 0);
        @(negedge clk);
        #1;
        check("grant_s01", s01_axis_tready, 1);
        @(negedge clk);
        s01_axis_tvalid = 0;
        #1;
        check("issue_s01_data", m00_axis_tdata, 32'hBBBB_0002);
        apply_reset();

        // Backpressure: stall m02 so the tag FIFO fills with s01 samples.
        add_packet(1, 24);
        build_expected();
        repeat (60) run_cycle(1'b1, 100);
        check("bp_accepted", ptr[1], TAG_DEPTH);
        check("bp_s01_tready", s01_axis_tready, 0);
        check("bp_s00_tready", s00_axis_tready, 0);
        check("bp_s02_tready", s02_axis_tready, 0);
        check("bp_m02_tvalid", m02_axis_tvalid, 1);
        run_until_done(3000, 100);

        // Randomized sessions with both requesters and mixed packet lengths.
        for (int s = 0; s < 3; s++) begin
            apply_reset();
            for (int r = 0; r < 2; r++) begin
                int npk;
                npk = $urandom_range(3, 6);
                for (int p = 0; p < npk; p++) add_packet(r, $urandom_range(1, 10));
            end
            build_expected();
            run_until_done(20000, 40 + 30 * s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
